instr_loader: RTL and testbench

- Byte-stream program loader that sits directly upstream of Datapath_Module.
- Drives the datapath's external load port (test_normal, ext_instr_we/addr/data, ext_data_write_en/addr/data) and its clr input.
- Receives framed commands over an 8-bit valid/ready stream (UART receiver or host bridge). Writes instruction or data memory word by word, then releases the core into normal mode with a clr pulse.

---
 rtl/instr_loader.sv | 198 +++++++++++++++++++
 tb/tb_instr_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: framed byte-stream loader for the datapath external load port and clr; define LOADER_CHECKSUM_EN for a per-frame XOR checksum byte
module instr_loader #(
  parameter int ADDR_W     = 16,
  parameter int MAX_WORDS  = 256,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              test_normal,
  output logic              ext_instr_we,
  output logic [ADDR_W-1:0] ext_instr_addr,
  output logic [15:0]       ext_instr_data,
  output logic              ext_data_write_en,
  output logic [ADDR_W-1:0] ext_data_addr,
  output logic [15:0]       ext_data_data,
  output logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] words_loaded,
  output logic              err
);
  typedef enum logic [3:0] {IDLE, CNT_H, CNT_L, W_H, W_L, WRITE, CLR, RUN, CHK} state_t;
  localparam logic [16:0] MAXW     = 17'(MAX_WORDS);
  localparam logic [3:0]  CLR_LAST = 4'(CLR_CYCLES - 1);
  state_t state_q, state_d, done_st;
  logic tgt_q, tgt_d;
  logic [15:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [7:0] hi_q, hi_d;
  logic [3:0] ccnt_q, ccnt_d;
  logic err_q, err_d, rdy_q, rdy_d, tn_q, tn_d, clr_q, clr_d, iwe_q, iwe_d, dwe_q, dwe_d;
  logic [ADDR_W-1:0] wl_q, wl_d, iaddr_q, iaddr_d, daddr_q, daddr_d;
  logic [15:0] idata_q, idata_d, ddata_q, ddata_d;
  logic fire, chk_bad, bad_load;
  assign fire = in_valid & rdy_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic bad_q, bad_d;
  assign done_st  = CHK;
  assign chk_bad  = in_data != csum_q;
  assign bad_load = bad_q;
  always_comb begin
    csum_d = csum_q;
    bad_d  = bad_q;
    if (fire) begin
      csum_d = (state_q == CNT_H) ? in_data : (state_q inside {CNT_L, W_H, W_L}) ? csum_q ^ in_data : csum_q;
      bad_d  = (state_q == CHK) ? chk_bad : bad_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      csum_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      bad_q  <= bad_d;
    end
  end
`else
  assign done_st  = IDLE;
  assign chk_bad  = 1'b0;
  assign bad_load = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    ccnt_d  = ccnt_q;
    err_d   = err_q;
    wl_d    = wl_q;
    iwe_d   = 1'b0;
    dwe_d   = 1'b0;
    iaddr_d = iaddr_q;
    idata_d = idata_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    case (state_q)
      IDLE: if (fire) begin
        if (in_data == 8'hA5 || in_data == 8'h5A) begin
          state_d = CNT_H;
          tgt_d   = in_data == 8'hA5;
          err_d   = 1'b0;
        end else if (in_data == 8'h3C && !bad_load) begin
          state_d = CLR;
          ccnt_d  = CLR_LAST;
          err_d   = 1'b0;
        end else err_d = 1'b1;
      end
      CNT_H: if (fire) begin
        cnt_d[15:8] = in_data;
        state_d     = CNT_L;
      end
      CNT_L: if (fire) begin
        cnt_d[7:0] = in_data;
        idx_d      = '0;
        if (cnt_q[15:8] == 8'h00 && in_data == 8'h00) begin
          wl_d    = '0;
          state_d = done_st;
        end else state_d = W_H;
      end
      W_H: if (fire) begin
        hi_d    = in_data;
        state_d = W_L;
      end
      W_L: if (fire) begin
        state_d = WRITE;
        // words past MAX_WORDS are consumed but never reach memory
        if ({1'b0, idx_q} < MAXW) begin
          iwe_d = tgt_q;
          dwe_d = !tgt_q;
          if (tgt_q) begin
            iaddr_d = ADDR_W'(idx_q);
            idata_d = {hi_q, in_data};
          end else begin
            daddr_d = ADDR_W'(idx_q);
            ddata_d = {hi_q, in_data};
          end
        end else err_d = 1'b1;
      end
      WRITE: begin
        idx_d = idx_q + 16'd1;
        if (idx_d == cnt_q) begin
          wl_d    = ({1'b0, cnt_q} > MAXW) ? ADDR_W'(MAXW) : ADDR_W'(cnt_q);
          state_d = done_st;
        end else state_d = W_H;
      end
      CLR: if (ccnt_q == 4'd0) state_d = RUN; else ccnt_d = ccnt_q - 4'd1;
      RUN: if (fire) begin
        if (in_data == 8'hC3) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else err_d = 1'b1;
      end
      CHK: if (fire) begin
        state_d = IDLE;
        err_d   = err_q | chk_bad;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d inside {IDLE, CNT_H, CNT_L, W_H, W_L, RUN, CHK};
    tn_d  = !(state_d inside {CLR, RUN});
    clr_d = state_d == CLR;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      ccnt_q  <= '0;
      err_q   <= 1'b0;
      wl_q    <= '0;
      rdy_q   <= 1'b0;
      tn_q    <= 1'b1;
      clr_q   <= 1'b0;
      iwe_q   <= 1'b0;
      dwe_q   <= 1'b0;
      iaddr_q <= '0;
      idata_q <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      ccnt_q  <= ccnt_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
      rdy_q   <= rdy_d;
      tn_q    <= tn_d;
      clr_q   <= clr_d;
      iwe_q   <= iwe_d;
      dwe_q   <= dwe_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end
  assign in_ready          = rdy_q;
  assign test_normal       = tn_q;
  assign clr               = clr_q;
  assign busy              = !(state_q inside {IDLE, RUN});
  assign err               = err_q;
  assign words_loaded      = wl_q;
  assign ext_instr_we      = iwe_q;
  assign ext_instr_addr    = iaddr_q;
  assign ext_instr_data    = idata_q;
  assign ext_data_write_en = dwe_q;
  assign ext_data_addr     = daddr_q;
  assign ext_data_data     = ddata_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized frames checked against a write-list model of instr_loader
module tb_instr_loader;
  localparam int MAXW = 256;
  logic clk = 1'b0, clr_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, test_normal, ext_instr_we, ext_data_write_en, clr, busy, err;
  logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data, words_loaded;
  int checks = 0, errors = 0, clr_cyc = 0, clr_tn_bad = 0;
  logic [32:0] exp_q[$], got_q[$];
  logic [15:0] words[$];
`ifdef LOADER_CHECKSUM_EN
  bit corrupt = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_loader dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .test_normal(test_normal), .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr),
    .ext_instr_data(ext_instr_data), .ext_data_write_en(ext_data_write_en),
    .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data), .clr(clr), .busy(busy),
    .words_loaded(words_loaded), .err(err)
  );

  always @(negedge clk) begin
    if (ext_instr_we) got_q.push_back({1'b1, ext_instr_addr, ext_instr_data});
    if (ext_data_write_en) got_q.push_back({1'b0, ext_data_addr, ext_data_data});
    if (clr) clr_cyc++;
    if (clr && test_normal) clr_tn_bad++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake byte %h in_ready %b required 1", b, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Model: word i of a frame lands at address i of the selected memory while i < MAXW
  task automatic send_load(input bit instr, input int maxgap);
    logic [15:0] n;
    logic [7:0] cs;
    n = 16'(words.size());
    exp_q.delete();
    got_q.delete();
    send_byte(instr ? 8'hA5 : 8'h5A, $urandom_range(maxgap));
    send_byte(n[15:8], $urandom_range(maxgap));
    send_byte(n[7:0], $urandom_range(maxgap));
    cs = n[15:8] ^ n[7:0];
    foreach (words[i]) begin
      send_byte(words[i][15:8], $urandom_range(maxgap));
      send_byte(words[i][7:0], $urandom_range(maxgap));
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
      if (i < MAXW) exp_q.push_back({instr, 16'(i), words[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(corrupt ? ~cs : cs, $urandom_range(maxgap));
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (test_normal !== 1'b1) begin errors++; $display("FAIL rst_test_normal got %b exp 1", test_normal); end
    checks++; if ({clr, busy, err, ext_instr_we, ext_data_write_en} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {clr, busy, err, ext_instr_we, ext_data_write_en}); end
    checks++; if ({words_loaded, ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data} !== 80'h0) begin errors++; $display("FAIL rst_vectors got %h exp 0", {words_loaded, ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data}); end
    clr_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready_early got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_load_instr;
    words = '{16'h1900, 16'hE020, 16'h0956};
    send_load(1'b1, 0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL instr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL instr_write[%0d] got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]); end
    end
    checks++; if (words_loaded !== 16'd3) begin errors++; $display("FAIL instr_words_loaded got %0d exp 3", words_loaded); end
  endtask

  task automatic test_load_data;
    words = '{16'h1234};
    send_load(1'b0, 0);
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL data_write got %0d entries first %h exp %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0, exp_q[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL data_busy got %b exp 0", busy); end
    checks++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL data_words_loaded got %0d exp 1", words_loaded); end
  endtask

  task automatic test_run_stop;
    clr_cyc = 0;
    clr_tn_bad = 0;
    send_byte(8'h3C, 0);
    @(negedge clk);
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL run_clr_start got %b exp 1", clr); end
    repeat (5) @(negedge clk);
    checks++; if (clr_cyc != 2) begin errors++; $display("FAIL run_clr_cycles got %0d exp 2", clr_cyc); end
    checks++; if (clr_tn_bad != 0) begin errors++; $display("FAIL run_clr_mode got %0d cycles with test_normal=1 exp 0", clr_tn_bad); end
    checks++; if ({test_normal, clr, in_ready, busy} !== 4'b0010) begin errors++; $display("FAIL run_state got %b exp 0010", {test_normal, clr, in_ready, busy}); end
    send_byte(8'h11, 0);
    @(negedge clk);
    checks++; if ({err, test_normal} !== 2'b10) begin errors++; $display("FAIL run_drop got err/tn %b exp 10", {err, test_normal}); end
    send_byte(8'hC3, 0);
    @(negedge clk);
    checks++; if ({test_normal, busy, err, in_ready} !== 4'b1001) begin errors++; $display("FAIL stop_state got %b exp 1001", {test_normal, busy, err, in_ready}); end
  endtask

  task automatic test_errors;
    got_q.delete();
    send_byte(8'h77, 0);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_cmd_err got %b exp 1", err); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bad_cmd_writes got %0d exp 0", got_q.size()); end
    words.delete();
    send_load(1'b1, 0);
    checks++; if ({err, busy, got_q.size() == 0} !== 3'b001) begin errors++; $display("FAIL zero_len got err/busy/empty %b exp 001", {err, busy, got_q.size() == 0}); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL zero_len_words got %0d exp 0", words_loaded); end
  endtask

  task automatic test_overflow;
    words.delete();
    for (int i = 0; i < 258; i++) words.push_back(16'($urandom));
    send_load(1'b0, 0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_write[%0d] got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]); end
    end
    checks++; if (words_loaded !== 16'(MAXW)) begin errors++; $display("FAIL ovf_words_loaded got %0d exp %0d", words_loaded, MAXW); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err); end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 8; f++) begin
      bit instr;
      int n;
      instr = 1'($urandom_range(1));
      n = $urandom_range(6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      send_load(instr, (f < 2) ? 0 : 3);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", f, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_write[%0d] got %h exp %h", f, i, (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]); end
      end
      checks++; if (words_loaded !== 16'(n) || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand%0d_status got wl %0d err %b busy %b exp wl %0d err 0 busy 0", f, words_loaded, err, busy, n); end
    end
  endtask

  task automatic test_mid_reset;
    words = '{16'hAAAA, 16'h5555};
    send_load(1'b0, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({in_ready, test_normal, clr, busy, err, ext_instr_we, ext_data_write_en} !== 7'b0100000) begin errors++; $display("FAIL midrst_flags got %b exp 0100000", {in_ready, test_normal, clr, busy, err, ext_instr_we, ext_data_write_en}); end
    checks++; if ({words_loaded, ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data} !== 80'h0) begin errors++; $display("FAIL midrst_vectors got %h exp 0", {words_loaded, ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data}); end
    clr_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
    words = '{16'h0102, 16'h0304};
    send_load(1'b1, 1);
    checks++; if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL midrst_reload got %0d entries first %h exp %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0, exp_q[0]); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    words = '{16'h1111, 16'h2222};
    corrupt = 1'b1;
    send_load(1'b1, 1);
    corrupt = 1'b0;
    checks++; if (got_q.size() != 2 || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL csum_writes got %0d entries exp 2", got_q.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_bad_err got %b exp 1", err); end
    clr_cyc = 0;
    send_byte(8'h3C, 0);
    repeat (6) @(negedge clk);
    checks++; if (clr_cyc != 0 || test_normal !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL csum_run_blocked got clr_cyc %0d tn %b err %b exp 0 1 1", clr_cyc, test_normal, err); end
    words = '{16'h3333};
    send_load(1'b0, 0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL csum_good_err got %b exp 0", err); end
    clr_cyc = 0;
    send_byte(8'h3C, 0);
    repeat (6) @(negedge clk);
    checks++; if (clr_cyc != 2 || test_normal !== 1'b0) begin errors++; $display("FAIL csum_run_ok got clr_cyc %0d tn %b exp 2 0", clr_cyc, test_normal); end
    send_byte(8'hC3, 0);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_load_instr();
    test_load_data();
    test_run_stop();
    test_errors();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
